// File: rtl/minigame_sequencer.sv
// minigame_sequencer
//   Round sequencer for N_JOGOS external minigame engines. Each round latches
//   the game and difficulty, waits INTERVALO cycles, pulses jogar for one
//   cycle, then waits for the active game's pronto and adds its score to a
//   saturating total. In tournament mode (modo=1) games 0..N_JOGOS-1 are
//   played back to back.
//
//   Optional feature macro: SEQ_TIMEOUT_EN
//     defined   -> EXECUCAO aborts after TIMEOUT cycles without pronto; the
//                  round scores 0 and timeout_flag is set (sticky).
//     undefined -> EXECUCAO waits forever; timeout_flag is tied to 0.
//
// Ports
//   clock, reset            clock / asynchronous active-high reset
//   iniciar                 start or restart request (honoured in INICIAL, FIM)
//   modo                    0 single game, 1 tournament
//   dificuldade, sel_jogo   sampled while in PREPARACAO
//   pronto_vec              per-game done flags
//   pontuacao_vec           per-game scores, game k at [k*PW +: PW]
//   jogar                   one-cycle start pulse to the active game
//   jogo_ativo              active game index
//   dificuldade_lat         latched difficulty
//   estado                  state code (INICIAL=0 .. FIM=6)
//   pontuacao_total         saturating accumulated score
//   rodada_fim              one-cycle pulse when a round ends
//   timeout_flag            sticky timeout indication
module minigame_sequencer #(
    parameter int N_JOGOS   = 3,
    parameter int SELW      = 2,
    parameter int PW        = 3,
    parameter int TW        = 6,
    parameter int INTERVALO = 5000,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic                    modo,
    input  logic                    dificuldade,
    input  logic [SELW-1:0]         sel_jogo,
    input  logic [N_JOGOS-1:0]      pronto_vec,
    input  logic [N_JOGOS*PW-1:0]   pontuacao_vec,
    output logic                    jogar,
    output logic [SELW-1:0]         jogo_ativo,
    output logic                    dificuldade_lat,
    output logic [3:0]              estado,
    output logic [TW-1:0]           pontuacao_total,
    output logic                    rodada_fim,
    output logic                    timeout_flag
);

    typedef enum logic [3:0] {
        S_INICIAL    = 4'd0,
        S_PREPARACAO = 4'd1,
        S_INTERVALO  = 4'd2,
        S_START      = 4'd3,
        S_EXECUCAO   = 4'd4,
        S_FIM_JOGO   = 4'd5,
        S_FIM        = 4'd6
    } state_t;

    localparam int NSEL = 2**SELW;
    localparam int CW   = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
    localparam int SW   = ((TW > PW) ? TW : PW) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(INTERVALO - 1);
    localparam logic [SW-1:0] TOT_MAX  = SW'({TW{1'b1}});

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            modo_lat;

    // Pad the per-game vectors out to the full select range so that any
    // jogo_ativo value indexes a defined bit (missing games read as 0).
    logic [NSEL-1:0] pronto_pad;
    logic [PW-1:0]   score_arr [NSEL];

    genvar k;
    generate
        for (k = 0; k < NSEL; k++) begin : g_pad
            if (k < N_JOGOS) begin : g_on
                assign pronto_pad[k] = pronto_vec[k];
                assign score_arr[k]  = pontuacao_vec[k*PW +: PW];
            end else begin : g_off
                assign pronto_pad[k] = 1'b0;
                assign score_arr[k]  = '0;
            end
        end
        // Present only for an out-of-range configuration; shows up by name in
        // elaboration reports.
        if (N_JOGOS < 2 || INTERVALO < 1 || TIMEOUT < 1) begin : g_bad_params
        end
    endgenerate

    // Zero-extended add, clamped to the largest TW-bit value.
    logic [SW-1:0] sum_ext;
    logic [TW-1:0] total_sat;
    assign sum_ext   = SW'(pontuacao_total) + SW'(score_arr[jogo_ativo]);
    assign total_sat = (sum_ext > TOT_MAX) ? TOT_MAX[TW-1:0] : sum_ext[TW-1:0];

    logic sel_ok, more_games;
    assign sel_ok     = {1'b0, sel_jogo}   < (SELW+1)'(N_JOGOS);
    assign more_games = {1'b0, jogo_ativo} < (SELW+1)'(N_JOGOS - 1);

    // Pulses are decodes of the state register: no input-to-output paths.
    assign estado     = state;
    assign jogar      = (state == S_START);
    assign rodada_fim = (state == S_FIM_JOGO);

`ifdef SEQ_TIMEOUT_EN
    localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
    logic [TOW-1:0] to_cnt;
    logic           to_flag;
    assign timeout_flag = to_flag;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= S_INICIAL;
            cnt             <= '0;
            modo_lat        <= 1'b0;
            jogo_ativo      <= '0;
            dificuldade_lat <= 1'b0;
            pontuacao_total <= '0;
`ifdef SEQ_TIMEOUT_EN
            to_cnt          <= '0;
            to_flag         <= 1'b0;
`endif
        end else begin
            // Counters idle at zero outside their own state.
            cnt <= '0;
`ifdef SEQ_TIMEOUT_EN
            to_cnt <= '0;
`endif
            case (state)
                S_INICIAL, S_FIM: begin
                    if (iniciar) begin
                        state           <= S_PREPARACAO;
                        pontuacao_total <= '0;
                        modo_lat        <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        to_flag         <= 1'b0;
`endif
                    end
                end
                S_PREPARACAO: begin
                    dificuldade_lat <= dificuldade;
                    modo_lat        <= modo;
                    if (modo) begin
                        jogo_ativo <= '0;
                        state      <= S_INTERVALO;
                    end else begin
                        jogo_ativo <= sel_jogo;
                        if (sel_ok)
                            state <= S_INTERVALO;
                    end
                end
                S_INTERVALO: begin
                    if (cnt == CNT_LAST)
                        state <= S_START;
                    else
                        cnt <= cnt + 1'b1;
                end
                S_START: state <= S_EXECUCAO;
                S_EXECUCAO: begin
                    if (pronto_pad[jogo_ativo]) begin
                        pontuacao_total <= total_sat;
                        state           <= S_FIM_JOGO;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        to_flag <= 1'b1;
                        state   <= S_FIM_JOGO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_FIM_JOGO: begin
                    if (modo_lat && more_games) begin
                        jogo_ativo <= jogo_ativo + 1'b1;
                        state      <= S_INTERVALO;
                    end else begin
                        state <= S_FIM;
                    end
                end
                default: state <= S_INICIAL;
            endcase
        end
    end

endmodule
